fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage of the pipelined RV32I core. Owns the PC and drives the instruction-memory address.
//  Captures the asynchronously-read instruction word into the IF/ID pipeline register consumed by decode.
//  Handles stall, redirect/flush (branch, jump) and halt (ECALL).
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset
//  NOP_INST  32'h0000_0013  bubble instruction (addi x0,x0,0) placed in IF/ID on flush/reset
// PORTS
//  clk              in   1   clock, all state updates on posedge
//  reset            in   1   synchronous, active-high
//  imem_addr        out  32  address to instruction memory (= pc, combinational)
//  imem_dout        in   32  instruction word returned asynchronously for imem_addr
//  stall            in   1   hazard unit: hold PC and IF/ID
//  redirect_valid   in   1   EX resolved taken branch/jump: load redirect_target, flush IF/ID
//  redirect_target  in   32  new PC; bits[1:0] forced to 0 before use
//  halt_req         in   1   ECALL/halt decoded: stop fetching
//  if_id_valid      out  1   IF/ID holds a real instruction
//  if_id_pc         out  32  PC of instruction in IF/ID
//  if_id_inst       out  32  instruction in IF/ID
//  if_id_pc_plus4   out  32  if_id_pc + 4 (mod 2^32)
//  halted           out  1   sticky halt flag
// BEHAVIOUR
//  - Reset (sync): pc<=RESET_PC, if_id_valid<=0, if_id_pc<=0, if_id_inst<=NOP_INST, if_id_pc_plus4<=4, halted<=0.
//    Reset mid-operation discards every in-flight state at that edge; perf counters (if present) clear to 0.
//  - imem_addr = pc combinationally; zero-cycle memory latency; fetched word latched at the same edge PC advances.
//  - Per-edge priority (reset excluded): halted > redirect_valid > stall > halt_req > normal.
//    halted:   pc, if_id_* held except if_id_valid<=0; stall, redirect and halt_req ignored until reset.
//    redirect: pc<={redirect_target[31:2],2'b00}; if_id_valid<=0, if_id_inst<=NOP_INST; overrides simultaneous stall.
//    stall:    pc and all if_id_* held unchanged (incl. valid).
//    halt_req: halted<=1; pc held; if_id_valid<=0, if_id_inst<=NOP_INST.
//    normal:   if_id_pc<=pc, if_id_inst<=imem_dout, if_id_pc_plus4<=pc+4, if_id_valid<=1; pc<=pc+4.
//  - Arithmetic: 32-bit unsigned, wrap-around; pc 32'hFFFF_FFFC advances to 32'h0000_0000.
//  - State machine (2 states): RUN -> HALT on halt_req (and no redirect/stall); HALT -> RUN only via reset.
//  - Throughput: one instruction per cycle when no stall/redirect; redirect costs one bubble.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt (32 each).
//    fetch: +1 per normal edge; stall: +1 per edge with stall & ~redirect & ~halted;
//    flush: +1 per redirect edge (not halted). All wrap mod 2^32, reset to 0.
//  FETCH_PERF_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Shared package cpu_pkg: NOP_INST, RESET_PC defaults, XLEN=32, fetch state encoding (FS_RUN, FS_HALT).
//  - One sub-module: pc_reg (PC register with sync reset, enable, load) instantiated once.
//  - IF/ID register, halt FSM and optional counters inline in fetch_stage.
// TESTING
//  1 reset 2 cycles, imem word k = 32'h100+k: imem_addr=0, if_id_valid=0, inst=0x13; then 0,4,8.. with inst 0x100,0x101..
//  2 stall high 3 cycles at pc=0x8: pc stays 0x8, if_id_* unchanged 3 cycles; resumes with pc 0x8 fetched next.
//  3 redirect_valid with target 0x43 and stall=1 same cycle: pc=0x40, if_id_valid=0, inst=0x13; next cycle fetches 0x40.
//  4 halt_req at pc=0x20: halted=1, pc frozen at 0x20, if_id_valid=0 forever; later redirect to 0x80 ignored.
//  5 redirect to 0xFFFF_FFFC then run: pc wraps to 0x0, if_id_pc_plus4 for 0xFFFF_FFFC reads 0x0.
//  6 reset asserted mid-run at pc=0x30 while halted: pc=0, halted=0, valid=0; FETCH_PERF_CNT_EN counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: data width, fetch defaults, fetch FSM encoding
// and small PC arithmetic helpers.
package cpu_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [0:0] {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory port, hazard/redirect controls and the
// IF/ID register outputs. master = fetch stage, slave = surrounding core.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_dout;
    logic            stall;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            halt_req;
    logic            if_id_valid;
    logic [XLEN-1:0] if_id_pc;
    logic [XLEN-1:0] if_id_inst;
    logic [XLEN-1:0] if_id_pc_plus4;
    logic            halted;

    modport master (
        output imem_addr,
        input  imem_dout,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        input  halt_req,
        output if_id_valid,
        output if_id_pc,
        output if_id_inst,
        output if_id_pc_plus4,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_dout,
        output stall,
        output redirect_valid,
        output redirect_target,
        output halt_req,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_inst,
        input  if_id_pc_plus4,
        input  halted
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous reset, load has priority over
// sequential increment (enable), otherwise holds.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en_i,
    input  logic            load_i,
    input  logic [XLEN-1:0] load_val_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next PC selection
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (en_i) begin
            pc_d = pc_inc(pc_q);
        end else begin
            pc_d = pc_q;
        end
    end

    // PC state register
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID register and sticky halt FSM.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            reset,
    fetch_stage_if.master   fif
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_s;
    logic            pc_en_s, pc_load_s;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] inst_q, inst_d;
    logic [XLEN-1:0] p4_q, p4_d;
    logic            fetch_ev_s, stall_ev_s, flush_ev_s;

    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .en_i      (pc_en_s),
        .load_i    (pc_load_s),
        .load_val_i(align_word(fif.redirect_target)),
        .pc_o      (pc_s)
    );

    // Edge priority: halted > redirect > stall > halt_req > sequential fetch
    always_comb begin
        state_d    = state_q;
        pc_en_s    = 1'b0;
        pc_load_s  = 1'b0;
        valid_d    = valid_q;
        ipc_d      = ipc_q;
        inst_d     = inst_q;
        p4_d       = p4_q;
        fetch_ev_s = 1'b0;
        stall_ev_s = 1'b0;
        flush_ev_s = 1'b0;
        case (state_q)
            FS_HALT: begin
                valid_d = 1'b0;
            end
            FS_RUN: begin
                if (fif.redirect_valid) begin
                    pc_load_s  = 1'b1;
                    valid_d    = 1'b0;
                    inst_d     = NOP_INST;
                    flush_ev_s = 1'b1;
                end else if (fif.stall) begin
                    stall_ev_s = 1'b1;
                end else if (fif.halt_req) begin
                    state_d = FS_HALT;
                    valid_d = 1'b0;
                    inst_d  = NOP_INST;
                end else begin
                    pc_en_s    = 1'b1;
                    valid_d    = 1'b1;
                    ipc_d      = pc_s;
                    inst_d     = fif.imem_dout;
                    p4_d       = pc_inc(pc_s);
                    fetch_ev_s = 1'b1;
                end
            end
            default: begin
                state_d = FS_HALT;
                valid_d = 1'b0;
            end
        endcase
    end

    // FSM state and IF/ID pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FS_RUN;
            valid_q <= 1'b0;
            ipc_q   <= 32'h0000_0000;
            inst_q  <= NOP_INST;
            p4_q    <= 32'h0000_0004;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            inst_q  <= inst_d;
            p4_q    <= p4_d;
        end
    end

    assign fif.imem_addr      = pc_s;
    assign fif.if_id_valid    = valid_q;
    assign fif.if_id_pc       = ipc_q;
    assign fif.if_id_inst     = inst_q;
    assign fif.if_id_pc_plus4 = p4_q;
    assign fif.halted         = (state_q == FS_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

    // Event counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + {31'd0, fetch_ev_s};
            stall_cnt_q <= stall_cnt_q + {31'd0, stall_ev_s};
            flush_cnt_q <= flush_cnt_q + {31'd0, flush_ev_s};
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`else
    logic unused_ev_s;
    assign unused_ev_s = fetch_ev_s ^ stall_ev_s ^ flush_ev_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus updates a behavioural model and
// queues expected post-edge state; a monitor compares after each rising edge.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic clk;
    logic reset;
    fetch_stage_if fif ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    fetch_stage dut (
        .clk  (clk),
        .reset(reset),
        .fif  (fif.master)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_stall_cnt(perf_stall_cnt),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word k holds 0x100 + k
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'h0000_0100 + (addr >> 2);
    endfunction

    assign fif.imem_dout = mem_word(fif.imem_addr);

    typedef struct {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic [31:0] p4;
        logic        halted;
        logic [31:0] nfetch;
        logic [31:0] nstall;
        logic [31:0] nflush;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state
    logic [31:0] m_pc, m_ipc, m_inst, m_p4, m_nf, m_ns, m_nfl;
    logic        m_valid, m_halt;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic step(input logic rst, input logic stl, input logic rdv,
                        input logic [31:0] tgt, input logic hlt);
        exp_t e;
        @(negedge clk);
        reset               = rst;
        fif.stall           = stl;
        fif.redirect_valid  = rdv;
        fif.redirect_target = tgt;
        fif.halt_req        = hlt;
        if (rst) begin
            m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_inst = 32'h13;
            m_p4 = 32'h4; m_halt = 1'b0; m_nf = 32'h0; m_ns = 32'h0; m_nfl = 32'h0;
        end else if (m_halt) begin
            m_valid = 1'b0;
        end else if (rdv) begin
            m_pc = tgt & 32'hFFFF_FFFC; m_valid = 1'b0; m_inst = 32'h13; m_nfl++;
        end else if (stl) begin
            m_ns++;
        end else if (hlt) begin
            m_halt = 1'b1; m_valid = 1'b0; m_inst = 32'h13;
        end else begin
            m_ipc = m_pc; m_inst = mem_word(m_pc); m_p4 = m_pc + 32'd4;
            m_valid = 1'b1; m_pc = m_pc + 32'd4; m_nf++;
        end
        e.pc = m_pc; e.valid = m_valid; e.ipc = m_ipc; e.inst = m_inst; e.p4 = m_p4;
        e.halted = m_halt; e.nfetch = m_nf; e.nstall = m_ns; e.nflush = m_nfl;
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Monitor: compare DUT state against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr",      fif.imem_addr,               e.pc);
                chk("if_id_valid",    {31'd0, fif.if_id_valid},    {31'd0, e.valid});
                chk("if_id_pc",       fif.if_id_pc,                e.ipc);
                chk("if_id_inst",     fif.if_id_inst,              e.inst);
                chk("if_id_pc_plus4", fif.if_id_pc_plus4,          e.p4);
                chk("halted",         {31'd0, fif.halted},         {31'd0, e.halted});
`ifdef FETCH_PERF_CNT_EN
                chk("perf_fetch_cnt", perf_fetch_cnt, e.nfetch);
                chk("perf_stall_cnt", perf_stall_cnt, e.nstall);
                chk("perf_flush_cnt", perf_flush_cnt, e.nflush);
`endif
            end
        end
    end

    initial begin
        int budget;
        reset               = 1'b1;
        fif.stall           = 1'b0;
        fif.redirect_valid  = 1'b0;
        fif.redirect_target = 32'h0;
        fif.halt_req        = 1'b0;

        // Reset, sequential fetch to pc=0x8, 3-cycle stall, resume
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        run(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        run(2);
        // Redirect to misaligned 0x43 with simultaneous stall
        step(1'b0, 1'b1, 1'b1, 32'h0000_0043, 1'b0);
        run(2);
        // Halt at pc=0x20, later redirect ignored
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        run(8);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        run(2);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        run(2);
        // Wrap-around from 0xFFFF_FFFC
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        run(3);
        // Reset while halted at pc=0x30
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        run(12);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        run(1);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        run(1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 10,
                 $urandom(),
                 $urandom_range(0, 99) < 3);
        end
        run(2);

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
